// File: rtl/rv32i_types.sv
// Shared CPU types: CDB broadcast entry and the FU-queue index mapping the
// CPU top and cdb_arbiter both rely on.
package rv32i_types;

  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        br_mispredict;
  } cdb_entry_t;

  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_BR_IDX  = 0;

  typedef logic [$clog2(CDB_NUM_REQ)-1:0] cdb_req_idx_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of i_mask at or after
// i_start, wrapping modulo N.
module rr_pick #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_mask,
  input  logic [W-1:0] i_start,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic [W-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      w_j = W'((int'(i_start) + k) % N);
      if (!o_any && i_mask[w_j]) begin
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: starved > branch > round-robin, one registered broadcast per cycle.
// Optional per-requester grant / conflict counters under CDB_ARB_PERF_EN.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter  int NUM_REQ    = CDB_NUM_REQ,
  parameter  int BR_IDX     = CDB_BR_IDX,
  parameter  int STARVE_MAX = 7,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  cdb_entry_t [NUM_REQ-1:0]  req_entry,
  input  logic                      cdb_stall,
  input  logic                      flush,
  output logic [NUM_REQ-1:0]        dequeue,
  output cdb_entry_t                cdb_out,
  output logic                      cdb_valid,
`ifdef CDB_ARB_PERF_EN
  output logic [NUM_REQ-1:0][31:0]  perf_grant_cnt,
  output logic [31:0]               perf_conflict_cnt,
`endif
  output logic [IDX_W-1:0]          grant_idx
);

  logic [NUM_REQ-1:0] w_nb_mask, w_starved_mask, w_nb_gnt, w_starved_gnt, w_grant;
  logic [IDX_W-1:0]   w_nb_idx, w_starved_idx, w_gidx;
  logic               w_nb_any, w_starved_any, w_any, w_br;

  logic [CNT_W-1:0]   r_cnt [NUM_REQ];
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_cdb_valid;
  cdb_entry_t         r_cdb_out;
  logic [IDX_W-1:0]   r_grant_idx;

  always_comb begin
    w_nb_mask      = '0;
    w_starved_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_nb_mask[i]      = req_valid[i] && (i != BR_IDX);
      w_starved_mask[i] = w_nb_mask[i] && (r_cnt[i] == CNT_W'(STARVE_MAX));
    end
  end

  rr_pick #(.N(NUM_REQ)) u_pick_starved (
    .i_mask (w_starved_mask),
    .i_start(r_rr_ptr),
    .o_grant(w_starved_gnt),
    .o_idx  (w_starved_idx),
    .o_any  (w_starved_any)
  );

  rr_pick #(.N(NUM_REQ)) u_pick_nb (
    .i_mask (w_nb_mask),
    .i_start(r_rr_ptr),
    .o_grant(w_nb_gnt),
    .o_idx  (w_nb_idx),
    .o_any  (w_nb_any)
  );

  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_br    = 1'b0;
    if (!cdb_stall && !flush) begin
      if (w_starved_any) begin
        w_grant = w_starved_gnt;
        w_gidx  = w_starved_idx;
      end else if (req_valid[BR_IDX]) begin
        w_grant[BR_IDX] = 1'b1;
        w_gidx          = IDX_W'(BR_IDX);
        w_br            = 1'b1;
      end else if (w_nb_any) begin
        w_grant = w_nb_gnt;
        w_gidx  = w_nb_idx;
      end
    end
  end

  assign w_any   = |w_grant;
  assign dequeue = rst_n ? w_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb_valid <= 1'b0;
      r_cdb_out   <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      r_cdb_valid <= w_any;
      if (w_any) begin
        r_cdb_out   <= req_entry[w_gidx];
        r_grant_idx <= w_gidx;
      end
      if (w_any && !w_br)
        r_rr_ptr <= (w_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
      // Flush beats stall; the branch slot never accumulates wait.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == BR_IDX || flush)
          r_cnt[i] <= '0;
        else if (!cdb_stall) begin
          if (req_valid[i] && !w_grant[i])
            r_cnt[i] <= (r_cnt[i] == CNT_W'(STARVE_MAX)) ? r_cnt[i] : r_cnt[i] + 1'b1;
          else
            r_cnt[i] <= '0;
        end
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_out   = r_cdb_out;
  assign grant_idx = r_grant_idx;

`ifdef CDB_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] r_perf_grant;
  logic [31:0]              r_perf_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_grant    <= '0;
      r_perf_conflict <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (w_grant[i]) r_perf_grant[i] <= r_perf_grant[i] + 32'd1;
      if (($countones(req_valid) > 1) && !cdb_stall && !flush)
        r_perf_conflict <= r_perf_conflict + 32'd1;
    end
  end

  assign perf_grant_cnt    = r_perf_grant;
  assign perf_conflict_cnt = r_perf_conflict;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations plus a
// randomized run against a behavioural arbitration model.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int N    = 4;
  localparam int BR   = 0;
  localparam int SMAX = 7;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_valid;
  cdb_entry_t [N-1:0]  req_entry;
  logic                cdb_stall;
  logic                flush;
  logic [N-1:0]        dequeue;
  cdb_entry_t          cdb_out;
  logic                cdb_valid;
  cdb_req_idx_t        grant_idx;
`ifdef CDB_ARB_PERF_EN
  logic [N-1:0][31:0]  perf_grant_cnt;
  logic [31:0]         perf_conflict_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cdb_arbiter #(.NUM_REQ(N), .BR_IDX(BR), .STARVE_MAX(SMAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_entry(req_entry),
    .cdb_stall(cdb_stall),
    .flush    (flush),
    .dequeue  (dequeue),
    .cdb_out  (cdb_out),
    .cdb_valid(cdb_valid),
`ifdef CDB_ARB_PERF_EN
    .perf_grant_cnt   (perf_grant_cnt),
    .perf_conflict_cnt(perf_conflict_cnt),
`endif
    .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state: what the bus must show next cycle, wait counts, rr start.
  int         m_cnt [N];
  int         m_ptr;
  logic       m_v;
  int         m_idx;
  cdb_entry_t m_out;

  always @(negedge clk) begin
    int g;
    int j;
    if (!rst_n) begin
      chk("reset_dequeue", 64'(dequeue), 64'd0);
      chk("reset_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("reset_grant_idx", 64'(grant_idx), 64'd0);
      chk("reset_cdb_out", 64'(cdb_out), 64'd0);
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_ptr = 0;
      m_v   = 1'b0;
      m_idx = 0;
      m_out = '0;
    end else begin
      chk("cdb_valid", 64'(cdb_valid), 64'(m_v));
      if (m_v) begin
        chk("grant_idx", 64'(grant_idx), 64'(m_idx));
        chk("cdb_out", 64'(cdb_out), 64'(m_out));
      end
      g = -1;
      if (!cdb_stall && !flush) begin
        for (int k = 0; k < N && g < 0; k++) begin
          j = (m_ptr + k) % N;
          if (j != BR && req_valid[j] && m_cnt[j] == SMAX) g = j;
        end
        if (g < 0 && req_valid[BR]) g = BR;
        for (int k = 0; k < N && g < 0; k++) begin
          j = (m_ptr + k) % N;
          if (j != BR && req_valid[j]) g = j;
        end
      end
      chk("dequeue", 64'(dequeue), (g >= 0) ? (64'd1 << g) : 64'd0);
      m_v = (g >= 0);
      if (g >= 0) begin
        m_out = req_entry[g];
        m_idx = g;
        if (g != BR) m_ptr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (i == BR || flush) m_cnt[i] = 0;
        else if (!cdb_stall) m_cnt[i] = (req_valid[i] && g != i) ? ((m_cnt[i] < SMAX) ? m_cnt[i] + 1 : SMAX) : 0;
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic s, input logic f);
    req_valid = v;
    cdb_stall = s;
    flush     = f;
    for (int i = 0; i < N; i++) begin
      req_entry[i].rob_idx       = 6'($urandom);
      req_entry[i].rd            = 5'($urandom);
      req_entry[i].data          = $urandom;
      req_entry[i].br_mispredict = 1'($urandom);
    end
  endtask

  // Advance to just after the next rising edge, where inputs change.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    drive(v, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    #4;
    chk("in_reset_dequeue", 64'(dequeue), 64'd0);
    tick();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] exp_rot [5];
  logic [N-1:0] pv;
  int           pf, ps;

  initial begin
    rst_n = 1'b1;
    drive('0, 1'b0, 1'b0);
    #1;
    do_reset(4'b1111);
    #4;
    chk("first_grant_branch", 64'(dequeue), 64'b0001);
    tick();
    #4;
    chk("first_bcast_valid", 64'(cdb_valid), 64'd1);
    chk("first_bcast_idx", 64'(grant_idx), 64'd0);

    // Non-branch rotation skips the branch slot.
    exp_rot[0] = 4'b0010; exp_rot[1] = 4'b0100; exp_rot[2] = 4'b1000;
    exp_rot[3] = 4'b0010; exp_rot[4] = 4'b0100;
    tick();
    do_reset(4'b1110);
    for (int c = 0; c < 5; c++) begin
      drive(4'b1110, 1'b0, 1'b0);
      #4;
      chk("rr_rotation", 64'(dequeue), 64'(exp_rot[c]));
      tick();
    end

    // Starvation overrides a continuously valid branch on the 8th cycle.
    do_reset(4'b0011);
    for (int c = 0; c < 9; c++) begin
      drive(4'b0011, 1'b0, 1'b0);
      #4;
      chk("starve_seq", 64'(dequeue), (c == 7) ? 64'b0010 : 64'b0001);
      tick();
    end

    // Stall blocks grants; branch goes first on release.
    do_reset(4'b0101);
    for (int c = 0; c < 3; c++) begin
      drive(4'b0101, 1'b1, 1'b0);
      #4;
      chk("stall_dequeue", 64'(dequeue), 64'd0);
      chk("stall_cdb_valid", 64'(cdb_valid), 64'd0);
      tick();
    end
    drive(4'b0101, 1'b0, 1'b0);
    #4;
    chk("stall_release", 64'(dequeue), 64'b0001);
    tick();

    // Flush in the cycle requester 2 would win; rr pointer survives it.
    do_reset(4'b1110);
    drive(4'b1110, 1'b0, 1'b0);
    #4;
    chk("flush_pre", 64'(dequeue), 64'b0010);
    tick();
    drive(4'b1110, 1'b0, 1'b1);
    #4;
    chk("flush_dequeue", 64'(dequeue), 64'd0);
    tick();
    drive(4'b1110, 1'b0, 1'b0);
    #4;
    chk("flush_kill_valid", 64'(cdb_valid), 64'd0);
    chk("flush_rr_kept", 64'(dequeue), 64'b0100);
    tick();

`ifdef CDB_ARB_PERF_EN
    do_reset(4'b1111);
    for (int c = 0; c < 10; c++) begin
      drive(4'b1111, 1'b0, 1'b0);
      tick();
    end
    drive('0, 1'b0, 1'b0);
    #4;
    chk("perf_grant0", 64'(perf_grant_cnt[0]), 64'd7);
    chk("perf_grant1", 64'(perf_grant_cnt[1]), 64'd1);
    chk("perf_grant2", 64'(perf_grant_cnt[2]), 64'd1);
    chk("perf_grant3", 64'(perf_grant_cnt[3]), 64'd1);
    chk("perf_conflict", 64'(perf_conflict_cnt), 64'd10);
    tick();
`endif

    // Randomized traffic with phase-varying request density.
    do_reset('0);
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        pf = int'($urandom_range(20, 90));
        ps = int'($urandom_range(0, 15));
      end
      for (int i = 0; i < N; i++) pv[i] = ($urandom_range(0, 99) < pf);
      drive(pv, ($urandom_range(0, 99) < ps), ($urandom_range(0, 99) < 4));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
